// File: rtl/plot_queue_writer.sv
// Clips the drawing engines' plot stream to the screen, queues it in a small FIFO and
// issues stallable framebuffer writes. Optional macro PLOT_DEDUP_EN drops repeated pixels.
module plot_queue_writer #(
  parameter int DEPTH = 8,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_x,
  input  logic [6:0]               in_y,
  input  logic [2:0]               in_colour,
  input  logic                     in_plot,
  output logic [14:0]              fb_addr,
  output logic [2:0]               fb_data,
  output logic                     fb_we,
  input  logic                     fb_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     idle,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [8:0]  XLIM     = SCR_W[8:0];
  localparam logic [7:0]  YLIM     = SCR_H[7:0];
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_valid;
  logic [14:0]   r_addr;
  logic [2:0]    r_data;
  logic          r_ovf;

  logic   w_elig;
  logic   w_req;
  logic   w_empty;
  logic   w_full;
  logic   w_accept;
  logic   w_pop;
  logic   w_push;
  logic   w_drop;
  entry_t w_in;
  entry_t w_tail;
  logic [14:0] w_addr;

  assign w_in    = '{x: in_x, y: in_y, c: in_colour};
  assign w_elig  = in_plot && ({1'b0, in_x} < XLIM) && ({1'b0, in_y} < YLIM);

`ifdef PLOT_DEDUP_EN
  entry_t r_last;
  logic   r_last_valid;

  assign w_req = w_elig && !(r_last_valid && (r_last == w_in));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last       <= '0;
      r_last_valid <= 1'b0;
    end else if (w_push) begin
      r_last       <= w_in;
      r_last_valid <= 1'b1;
    end
  end
`else
  assign w_req = w_elig;
`endif

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_CNT);
  assign w_accept = r_valid && fb_ready;
  // The output register can take a new entry whenever it is free or being emptied this edge.
  assign w_pop    = !w_empty && (!r_valid || fb_ready);
  assign w_push   = w_req && (!w_full || w_pop);
  assign w_drop   = w_req && w_full && !w_pop;

  assign w_tail = r_mem[r_rptr];
  // y*160 as y*128 + y*32, avoiding a multiplier.
  assign w_addr = {1'b0, w_tail.y, 7'b0} + {3'b0, w_tail.y, 5'b0} + {7'b0, w_tail.x};

  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wptr] <= w_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_valid <= 1'b1;
        r_addr  <= w_addr;
        r_data  <= w_tail.c;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign fb_we    = r_valid;
  assign fb_addr  = r_addr;
  assign fb_data  = r_data;
  assign count    = r_count;
  assign full     = w_full;
  assign idle     = w_empty && !r_valid;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_plot_queue_writer.sv
// Randomized self-checking bench for plot_queue_writer against a queue-based reference model.
module tb_plot_queue_writer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_x = '0;
  logic [6:0]  in_y = '0;
  logic [2:0]  in_colour = '0;
  logic        in_plot = 1'b0;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we;
  logic        fb_ready = 1'b0;
  logic [3:0]  count;
  logic        full;
  logic        idle;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;

  plot_queue_writer #(.DEPTH(DEPTH), .SCR_W(160), .SCR_H(120)) dut (
    .clk(clk), .rst(rst), .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
    .in_plot(in_plot), .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
    .fb_ready(fb_ready), .count(count), .full(full), .idle(idle), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending pixels plus one pending framebuffer write.
  typedef struct {int x; int y; int c;} px_t;
  px_t mq[$];
  bit  m_valid;
  int  m_addr, m_data;
  bit  m_ovf;
  bit  m_last_v;
  px_t m_last;
  int  m_wr[$];
  int  dut_wr[$];

  typedef logic [25:0] vec_t;

  function automatic vec_t obs();
    return {fb_we, fb_addr, fb_data, count, full, idle, overflow};
  endfunction

  function automatic vec_t exp_vec();
    return {m_valid, 15'(m_addr), 3'(m_data), 4'(mq.size()),
            mq.size() == DEPTH, (mq.size() == 0) && !m_valid, m_ovf};
  endfunction

  task automatic model_edge(input bit p, input int x, input int y, input int c,
                            input bit rdy, input bit r);
    bit elig, pop, fullm;
    px_t e;
    if (m_valid && rdy) m_wr.push_back(m_addr * 8 + m_data);
    if (r) begin
      mq.delete(); m_valid = 0; m_addr = 0; m_data = 0; m_ovf = 0; m_last_v = 0;
      return;
    end
    pop   = (mq.size() > 0) && (!m_valid || rdy);
    fullm = (mq.size() == DEPTH);
    elig  = p && x < 160 && y < 120;
`ifdef PLOT_DEDUP_EN
    if (m_last_v && m_last.x == x && m_last.y == y && m_last.c == c) elig = 0;
`endif
    if (elig && fullm && !pop) m_ovf = 1;
    if (pop) begin
      e = mq.pop_front();
      m_valid = 1; m_addr = e.y * 160 + e.x; m_data = e.c;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (elig && (!fullm || pop)) begin
      e.x = x; e.y = y; e.c = c;
      mq.push_back(e);
      m_last = e; m_last_v = 1;
    end
  endtask

  // Drive one cycle of inputs, log any DUT write taken at the coming edge, advance the model.
  task automatic cycle(input bit p, input int x, input int y, input int c,
                       input bit rdy, input bit r);
    @(negedge clk);
    in_plot = p; in_x = 8'(x); in_y = 7'(y); in_colour = 3'(c); fb_ready = rdy; rst = r;
    if (fb_we && fb_ready) dut_wr.push_back(int'(fb_addr) * 8 + int'(fb_data));
    @(posedge clk);
    model_edge(p, x, y, c, rdy, r);
    #1;
  endtask

  task automatic clear_logs();
    m_wr.delete(); dut_wr.delete();
  endtask

  task automatic test_reset();
    vec_t rv;
    rv = {1'b0, 15'd0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0};
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 3, 4, 5, 1, 1);
    if (obs() !== rv) begin
      miscompares++; $display("FAIL reset: got %h exp %h", obs(), rv);
    end
    vectors++;
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_single();
    clear_logs();
    cycle(1, 10, 20, 3, 1, 0);
    if (fb_we !== 1'b0 || count !== 4'd1) begin
      miscompares++; $display("FAIL single_lat1: we %b cnt %0d exp we 0 cnt 1", fb_we, count);
    end
    vectors++;
    cycle(0, 0, 0, 0, 1, 0);
    if ({fb_we, fb_addr, fb_data} !== {1'b1, 15'd3210, 3'd3}) begin
      miscompares++;
      $display("FAIL single_write: we %b addr %0d data %0d exp 1 3210 3", fb_we, fb_addr, fb_data);
    end
    vectors++;
    cycle(0, 0, 0, 0, 1, 0);
    if (fb_we !== 1'b0 || idle !== 1'b1) begin
      miscompares++; $display("FAIL single_done: we %b idle %b exp 0 1", fb_we, idle);
    end
    vectors++;
    if (obs() !== exp_vec()) begin
      miscompares++; $display("FAIL single_model: got %h exp %h", obs(), exp_vec());
    end
    vectors++;
  endtask

  task automatic test_clip();
    int xs[3] = '{160, 0, 255};
    int ys[3] = '{0, 120, 127};
    for (int i = 0; i < 3; i++) begin
      cycle(1, xs[i], ys[i], 1, 1, 0);
      cycle(0, 0, 0, 0, 1, 0);
      if (fb_we !== 1'b0 || count !== 4'd0 || overflow !== 1'b0) begin
        miscompares++;
        $display("FAIL clip%0d: we %b cnt %0d ovf %b exp 0 0 0", i, fb_we, count, overflow);
      end
      vectors++;
    end
  endtask

  task automatic test_back_to_back();
    int expw[$];
    int x, y, c;
    clear_logs();
    for (int k = 1; k <= 23; k++) begin
      if (k <= 20) begin
        x = k * 7; y = $urandom_range(0, 119); c = $urandom_range(0, 7);
        expw.push_back((y * 160 + x) * 8 + c);
        cycle(1, x, y, c, 1, 0);
      end else begin
        cycle(0, 0, 0, 0, 1, 0);
      end
      if (fb_we !== ((k >= 2) && (k <= 21)) || count > 4'd1 || overflow !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b cyc%0d: we %b cnt %0d ovf %b", k, fb_we, count, overflow);
      end
      vectors++;
      if (obs() !== exp_vec()) begin
        miscompares++; $display("FAIL b2b_model cyc%0d: got %h exp %h", k, obs(), exp_vec());
      end
      vectors++;
    end
    if (dut_wr.size() != 20 || dut_wr != expw) begin
      miscompares++; $display("FAIL b2b_order: got %0d writes exp 20 in order", dut_wr.size());
    end
    vectors++;
  endtask

  task automatic test_stall_overflow();
    int expw[$];
    int y, c;
    clear_logs();
    for (int i = 0; i < 10; i++) begin
      y = $urandom_range(0, 119); c = $urandom_range(0, 7);
      if (i < 9) expw.push_back((y * 160 + i) * 8 + c);
      cycle(1, i, y, c, 0, 0);
      if (i == 8 && (full !== 1'b1 || overflow !== 1'b0 || fb_we !== 1'b1)) begin
        miscompares++; $display("FAIL stall_full: full %b ovf %b we %b exp 1 0 1", full, overflow, fb_we);
      end
      if (i == 9 && (full !== 1'b1 || overflow !== 1'b1)) begin
        miscompares++; $display("FAIL stall_ovf: full %b ovf %b exp 1 1", full, overflow);
      end
      if (i >= 8) vectors++;
    end
    cycle(0, 0, 0, 0, 0, 0);
    if (obs() !== exp_vec()) begin
      miscompares++; $display("FAIL stall_hold: got %h exp %h", obs(), exp_vec());
    end
    vectors++;
    for (int i = 0; i < 14; i++) begin
      cycle(0, 0, 0, 0, 1, 0);
      if (obs() !== exp_vec()) begin
        miscompares++; $display("FAIL drain_model cyc%0d: got %h exp %h", i, obs(), exp_vec());
      end
      vectors++;
    end
    if (dut_wr.size() != 9 || dut_wr != expw || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_writes: got %0d writes ovf %b exp 9 in order ovf 1", dut_wr.size(), overflow);
    end
    vectors++;
  endtask

  task automatic test_midreset();
    clear_logs();
    for (int i = 0; i < 6; i++) cycle(1, 20 + i, 30, 2, 0, 0);
    if (count !== 4'd5 || fb_we !== 1'b1) begin
      miscompares++; $display("FAIL midrst_pre: cnt %0d we %b exp 5 1", count, fb_we);
    end
    vectors++;
    cycle(0, 0, 0, 0, 0, 1);
    if (fb_we !== 1'b0 || count !== 4'd0 || idle !== 1'b1 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst: we %b cnt %0d idle %b ovf %b exp 0 0 1 0", fb_we, count, idle, overflow);
    end
    vectors++;
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 0);
    if (dut_wr.size() != 0) begin
      miscompares++; $display("FAIL midrst_nowrite: got %0d writes exp 0", dut_wr.size());
    end
    vectors++;
  endtask

  task automatic test_dedup();
    int n;
`ifdef PLOT_DEDUP_EN
    n = 2;
`else
    n = 3;
`endif
    clear_logs();
    cycle(1, 5, 5, 1, 1, 0);
    cycle(1, 5, 5, 1, 1, 0);
    cycle(1, 5, 5, 2, 1, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 0);
    if (dut_wr.size() != n || overflow !== 1'b0) begin
      miscompares++; $display("FAIL dedup: got %0d writes exp %0d", dut_wr.size(), n);
    end
    vectors++;
  endtask

  task automatic test_random();
    bit p, rdy, r;
    clear_logs();
    for (int i = 0; i < 600; i++) begin
      p   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 6);
      r   = ($urandom_range(0, 199) == 0);
      cycle(p, $urandom_range(0, 170), $urandom_range(0, 125), $urandom_range(0, 1), rdy, r);
      if (obs() !== exp_vec()) begin
        miscompares++; $display("FAIL rand cyc%0d: got %h exp %h", i, obs(), exp_vec());
      end
      vectors++;
    end
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0, 1, 0);
    if (dut_wr != m_wr) begin
      miscompares++;
      $display("FAIL rand_order: got %0d writes exp %0d", dut_wr.size(), m_wr.size());
    end
    vectors++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_clip();
    test_back_to_back();
    test_stall_overflow();
    test_midreset();
    test_dedup();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
